// File: rtl/dram_sched_pkg.sv
// Shared types and default widths for the DRAM command scheduler.
// Refresh support is enabled by defining DRAM_SCHED_REFRESH_EN.
package dram_sched_pkg;

  localparam int unsigned DEF_DEPTH          = 4;
  localparam int unsigned DEF_ADDR_W         = 16;
  localparam int unsigned DEF_DATA_W         = 8;
  localparam int unsigned DEF_REFRESH_PERIOD = 512;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_REFRESH
  } sched_state_t;

  // Command record at default widths; the scheduler flattens the same field order.
  typedef struct packed {
    logic                  rw;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/dram_cmd_fifo.sv
// Parameterised synchronous FIFO with registered occupancy count and
// combinational head; push when full and pop when empty are dropped.
module dram_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 25
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count != FULL_CNT);
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/dram_cmd_scheduler.sv
// Host command FIFO + single-outstanding req/ack issue FSM to the DRAM controller.
// Define DRAM_SCHED_REFRESH_EN to add the periodic refresh timer and REFRESH state.
module dram_cmd_scheduler
  import dram_sched_pkg::*;
#(
  parameter int unsigned DEPTH          = DEF_DEPTH,
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter int unsigned REFRESH_PERIOD = DEF_REFRESH_PERIOD
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_rw,
  input  logic [ADDR_W-1:0]      cmd_addr,
  input  logic [DATA_W-1:0]      cmd_wdata,
  output logic                   rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   mc_req,
  output logic                   mc_rw,
  output logic [ADDR_W-1:0]      mc_addr,
  output logic [DATA_W-1:0]      mc_wdata,
  input  logic                   mc_ack,
  input  logic [DATA_W-1:0]      mc_rdata,
  output logic                   mc_refresh_req,
  input  logic                   mc_refresh_ack,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   refresh_miss
);

  localparam int unsigned CMD_W = 1 + ADDR_W + DATA_W;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  sched_state_t     state;
  logic             push;
  logic             pop;
  logic [CMD_W-1:0] head;

  // Ready is a function of the registered count only, so a same-cycle pop never frees a slot.
  assign cmd_ready = (fifo_count != FULL_CNT);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == ST_ISSUE) && mc_ack;

  dram_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .din     ({cmd_rw, cmd_addr, cmd_wdata}),
    .pop     (pop),
    .head    (head),
    .count   (fifo_count)
  );

`ifdef DRAM_SCHED_REFRESH_EN
  localparam int unsigned TMR_W = $clog2(REFRESH_PERIOD);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(REFRESH_PERIOD - 1);

  logic [TMR_W-1:0] timer;
  logic             refresh_pend;
  logic             refresh_done;

  assign refresh_done = (state == ST_REFRESH) && mc_refresh_ack;

  // A wrap always (re)sets pending, so an ack on the wrap edge leaves one refresh owed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer        <= '0;
      refresh_pend <= 1'b0;
      refresh_miss <= 1'b0;
    end else begin
      timer <= (timer == TMR_LAST) ? '0 : timer + 1'b1;
      if (timer == TMR_LAST) begin
        refresh_pend <= 1'b1;
        if (refresh_pend && !refresh_done) refresh_miss <= 1'b1;
      end else if (refresh_done) begin
        refresh_pend <= 1'b0;
      end
    end
  end
`else
  logic unused_refresh_ack;
  assign unused_refresh_ack = mc_refresh_ack;
  assign mc_refresh_req     = 1'b0;
  assign refresh_miss       = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      mc_req    <= 1'b0;
      mc_rw     <= 1'b0;
      mc_addr   <= '0;
      mc_wdata  <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
`ifdef DRAM_SCHED_REFRESH_EN
      mc_refresh_req <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
`ifdef DRAM_SCHED_REFRESH_EN
          if (refresh_pend) begin
            state          <= ST_REFRESH;
            mc_refresh_req <= 1'b1;
          end else
`endif
          if (fifo_count != '0) begin
            state                         <= ST_ISSUE;
            mc_req                        <= 1'b1;
            {mc_rw, mc_addr, mc_wdata}    <= head;
          end
        end
        ST_ISSUE: begin
          if (mc_ack) begin
            state  <= ST_IDLE;
            mc_req <= 1'b0;
            if (mc_rw) begin
              rsp_valid <= 1'b1;
              rsp_rdata <= mc_rdata;
            end
          end
        end
`ifdef DRAM_SCHED_REFRESH_EN
        ST_REFRESH: begin
          if (mc_refresh_ack) begin
            state          <= ST_IDLE;
            mc_refresh_req <= 1'b0;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/dram_cmd_scheduler.md
# dram_cmd_scheduler

Front-end scheduler that sits directly upstream of the DRAM controller. It buffers host read/write commands in a small FIFO, issues them one at a time over a level req/ack handshake, returns read data to the host, and injects periodic refresh requests that take priority over queued commands at command boundaries.

## Interface
Parameters:
- DEPTH, 4: command FIFO entries (power of two, ≥2)
- ADDR_W, 16: address width
- DATA_W, 8: data width
- REFRESH_PERIOD, 512: clock cycles between refresh requests (≥8)

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  host command present
- cmd_ready  out  1  FIFO can accept (count < DEPTH)
- cmd_rw  in  1  1 = read, 0 = write
- cmd_addr  in  ADDR_W  command address
- cmd_wdata  in  DATA_W  write data (ignored for reads)
- rsp_valid  out  1  one-cycle pulse, read data valid
- rsp_rdata  out  DATA_W  read data
- mc_req  out  1  command request to controller, held until mc_ack
- mc_rw  out  1  command direction
- mc_addr  out  ADDR_W  command address
- mc_wdata  out  DATA_W  write data
- mc_ack  in  1  controller completed command (read data valid same cycle)
- mc_rdata  in  DATA_W  read data from controller
- mc_refresh_req  out  1  refresh request, held until mc_refresh_ack
- mc_refresh_ack  in  1  refresh completed
- fifo_count  out  $clog2(DEPTH)+1  occupied entries
- refresh_miss  out  1  sticky: a refresh interval expired while previous refresh still pending

## Operation
- Reset: all outputs 0 (cmd_ready reads 1 once reset_n high, derived from count=0); FIFO emptied, timer 0, FSM IDLE, refresh pending 0, refresh_miss 0. Assertion mid-transaction drops mc_req/mc_refresh_req immediately; queued commands are lost.
- Push on cmd_valid && cmd_ready at rising edge. cmd_ready depends only on registered count; no combinational path from mc_ack (a pop in the same cycle does not make a full FIFO ready).
- FSM states: IDLE, ISSUE, REFRESH.
  - IDLE: if refresh pending → REFRESH; else if FIFO non-empty → ISSUE, registering head into mc_rw/mc_addr/mc_wdata; else stay.
  - ISSUE: mc_req=1, mc_* stable. On mc_ack: pop head, deassert mc_req, → IDLE; if read, rsp_rdata<=mc_rdata, rsp_valid=1 next cycle.
  - REFRESH: mc_refresh_req=1; on mc_refresh_ack → IDLE, clear pending.
- Refresh timer counts 0..REFRESH_PERIOD-1 continuously, wraps; wrap sets pending. Refresh never preempts ISSUE.
- Wrap while pending already 1 (and no ack that edge) → refresh_miss set, pending stays 1 (no double count).
- Wrap coincident with mc_refresh_ack → pending remains 1, refresh_miss unchanged.
- Simultaneous push and pop: count unchanged, pointers wrap modulo DEPTH.
- mc_ack while not in ISSUE, or mc_refresh_ack while not in REFRESH: ignored.

## Timing
- Command accepted at edge N into empty FIFO, FSM IDLE, no refresh pending: mc_req high after edge N+1.
- mc_ack sampled at edge M: mc_req low and rsp_valid high (reads) during cycle after M; next mc_req earliest after edge M+1 (one idle cycle between commands).
- fifo_count updates the cycle after push/pop edge.
- First refresh pending after edge REFRESH_PERIOD-1 following reset release.

## Configuration
- DRAM_SCHED_REFRESH_EN defined: refresh timer, REFRESH state, mc_refresh_req and refresh_miss behave as above.
- Not defined: timer and REFRESH state removed; mc_refresh_req and refresh_miss tied 0; mc_refresh_ack ignored; FSM is IDLE/ISSUE only.

## Structure
- Package dram_sched_pkg: FSM state enum, default widths, command struct type (rw, addr, wdata).
- Sub-module dram_cmd_fifo: parameterised synchronous FIFO (push/pop/count/head), reused elsewhere.

## Test plan
- Write 0x0010/0xA5 then read 0x0010, mc_ack 2 cycles after each mc_req with mc_rdata=0xA5 → mc_addr=0x0010 both, mc_rw 0 then 1, one rsp_valid with rsp_rdata=0xA5.
- Push 5 commands back-to-back with mc_ack held low → 4 accepted, cmd_ready low, fifo_count=4; release ack → drained in order, 4 handshakes.
- REFRESH_PERIOD=16, command in ISSUE at wrap → mc_refresh_req asserts only after mc_ack, before next queued command.
- Hold mc_refresh_ack low for 2 periods → refresh_miss=1 and stays 1 after ack.
- Assert reset_n low during ISSUE with 3 queued → mc_req drops immediately, fifo_count=0, no rsp_valid after release.
- Build without DRAM_SCHED_REFRESH_EN, run 3×REFRESH_PERIOD → mc_refresh_req never 1.
